// File: rtl/stopwatch_ctrl.sv
// Stopwatch control unit: key debounce/edge detection, 100 Hz prescaler,
// IDLE/RUN/PAUSE sequencing and display-freeze strobes for the datapath.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key3,
  input  logic       key2,
  input  logic       key1,
  input  logic       key0,
  output logic [1:0] state,
  output logic       counting,
  output logic       paused,
  output logic       frozen,
  output logic       tick,
  output logic       cnt_clr,
  output logic       cnt_inc,
  output logic       disp_load
);

  localparam int unsigned NKEYS = 4;
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW    = $clog2(DEB_CYCLES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  // Key conditioning: all vectors are {key3, key2, key1, key0}, 1 = released.
  logic [NKEYS-1:0] key_s1;
  logic [NKEYS-1:0] key_s2;
  logic [NKEYS-1:0] key_deb;
  logic [NKEYS-1:0] key_deb_d;
  logic [NKEYS-1:0] evt;
  logic [DW-1:0]    deb_cnt [NKEYS];

  // Synchronize, debounce, and turn each accepted press into a 1-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1    <= '1;
      key_s2    <= '1;
      key_deb   <= '1;
      key_deb_d <= '1;
      evt       <= '0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      key_s1    <= {key3, key2, key1, key0};
      key_s2    <= key_s1;
      key_deb_d <= key_deb;
      evt       <= key_deb_d & ~key_deb;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (key_s2[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          key_deb[i] <= key_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  state_t        state_q;
  state_t        state_n;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_n;
  logic          frozen_n;
  logic          tick_n;
  logic          clr_n;
  logic          load_n;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      counting  <= 1'b0;
      paused    <= 1'b0;
      frozen    <= 1'b0;
      tick      <= 1'b0;
      cnt_clr   <= 1'b0;
      cnt_inc   <= 1'b0;
      disp_load <= 1'b0;
    end else begin
      state_q   <= state_n;
      presc_q   <= presc_n;
      counting  <= (state_n != ST_IDLE);
      paused    <= (state_n == ST_PAUSE);
      frozen    <= frozen_n;
      tick      <= tick_n;
      cnt_clr   <= clr_n;
      cnt_inc   <= tick_n;
      disp_load <= load_n;
    end
  end

  assign state = state_q;

  // Next state: the tick is decided from the current RUN cycle before any
  // key event, so an event landing on a tick cycle never swallows the tick.
  always_comb begin
    state_n  = state_q;
    presc_n  = presc_q;
    frozen_n = frozen;
    tick_n   = 1'b0;
    clr_n    = 1'b0;
    load_n   = 1'b0;

    if (state_q == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_n = '0;
        tick_n  = 1'b1;
        load_n  = ~frozen;
      end else begin
        presc_n = presc_q + PW'(1);
      end
    end

    // One event per cycle, key3 > key2 > key1 > key0; the rest are dropped.
    if (evt[3]) begin
      state_n  = ST_IDLE;
      clr_n    = 1'b1;
      frozen_n = 1'b0;
      presc_n  = '0;
    end else if (evt[2]) begin
      case (state_q)
        ST_IDLE: begin
          state_n = ST_RUN;
          presc_n = '0;
        end
        ST_RUN:   state_n = ST_PAUSE;
        ST_PAUSE: state_n = ST_RUN;
        default:  state_n = ST_IDLE;
      endcase
    end else if (evt[1]) begin
      if (state_q == ST_RUN) begin
        frozen_n = 1'b1;
        load_n   = 1'b1;
      end
    end else if (evt[0]) begin
      if (state_q == ST_RUN) begin
        frozen_n = 1'b0;
        load_n   = 1'b1;
      end
    end

    if (state_q != ST_IDLE && state_q != ST_RUN && state_q != ST_PAUSE) begin
      state_n = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a cycle model pushes expected outputs per edge,
// a monitor pops and compares; scenario checks use fixed expected numbers.
module tb_stopwatch_ctrl;

  localparam int unsigned TICK_DIV   = 5;
  localparam int unsigned DEB_CYCLES = 4;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       key3 = 1'b1;
  logic       key2 = 1'b1;
  logic       key1 = 1'b1;
  logic       key0 = 1'b1;
  logic [1:0] state;
  logic       counting;
  logic       paused;
  logic       frozen;
  logic       tick;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       disp_load;

  stopwatch_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key3     (key3),
    .key2     (key2),
    .key1     (key1),
    .key0     (key0),
    .state    (state),
    .counting (counting),
    .paused   (paused),
    .frozen   (frozen),
    .tick     (tick),
    .cnt_clr  (cnt_clr),
    .cnt_inc  (cnt_inc),
    .disp_load(disp_load)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Expected {state, counting, paused, frozen, tick, cnt_clr, cnt_inc, disp_load}
  logic [8:0] exp_q[$];

  // Reference model, working on raw key samples: a key is accepted after
  // DEB_CYCLES identical raw samples and acted on 4 edges later (2 sync + edge + act).
  logic [3:0] m_lvl;
  int         m_run [4];
  logic [3:0] m_dly [4];
  logic [1:0] m_state;
  int         m_phase;
  logic       m_frozen;

  always @(posedge clk) begin : model
    logic [3:0] raw;
    logic [3:0] fresh;
    logic [3:0] act;
    logic       m_tick;
    logic       m_clr;
    logic       m_load;
    raw = {key3, key2, key1, key0};
    if (rst) begin
      m_lvl    = 4'hF;
      m_state  = 2'b00;
      m_phase  = 0;
      m_frozen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0;
        m_dly[i] = 4'h0;
      end
      exp_q.push_back(9'd0);
    end else begin
      fresh = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (raw[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DEB_CYCLES)) begin
            m_lvl[i] = raw[i];
            m_run[i] = 0;
            fresh[i] = ~raw[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      act      = m_dly[3];
      m_dly[3] = m_dly[2];
      m_dly[2] = m_dly[1];
      m_dly[1] = m_dly[0];
      m_dly[0] = fresh;

      m_tick = 1'b0;
      m_clr  = 1'b0;
      m_load = 1'b0;
      if (m_state == 2'b01) begin
        m_phase++;
        if (m_phase == int'(TICK_DIV)) begin
          m_phase = 0;
          m_tick  = 1'b1;
          m_load  = !m_frozen;
        end
      end
      if (act[3]) begin
        m_state  = 2'b00;
        m_clr    = 1'b1;
        m_frozen = 1'b0;
        m_phase  = 0;
      end else if (act[2]) begin
        if (m_state == 2'b00) begin
          m_state = 2'b01;
          m_phase = 0;
        end else if (m_state == 2'b01) begin
          m_state = 2'b10;
        end else begin
          m_state = 2'b01;
        end
      end else if (act[1] && m_state == 2'b01) begin
        m_frozen = 1'b1;
        m_load   = 1'b1;
      end else if (act[0] && m_state == 2'b01) begin
        m_frozen = 1'b0;
        m_load   = 1'b1;
      end
      exp_q.push_back({m_state, m_state != 2'b00, m_state == 2'b10, m_frozen,
                       m_tick, m_clr, m_tick, m_load});
    end
  end

  int s_tick = 0;
  int s_inc  = 0;
  int s_load = 0;
  int s_clr  = 0;

  // Monitor: compare every edge's outputs and keep strobe totals.
  always @(posedge clk) begin : monitor
    logic [8:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("outs", 32'({state, counting, paused, frozen, tick, cnt_clr, cnt_inc, disp_load}),
               32'(e));
    end else begin
      check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
    end
    s_tick = s_tick + int'(tick);
    s_inc  = s_inc + int'(cnt_inc);
    s_load = s_load + int'(disp_load);
    s_clr  = s_clr + int'(cnt_clr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t0;
    int l0;
    int i0;
    int c0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_state", 32'({state, counting, paused, frozen, tick, cnt_clr, cnt_inc, disp_load}),
             32'd0);
    repeat (4) @(negedge clk);

    // Start from IDLE: latency to RUN, then first tick
    key2 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (state != 2'b01 && k < 40);
    check_eq("run_latency", 32'(k - 1), 32'd7);
    k = 0;
    do begin @(negedge clk); k++; end while (tick != 1'b1 && k < 40);
    check_eq("first_tick", 32'(k), 32'd5);
    check_eq("tick_strobes", 32'({tick, cnt_inc, disp_load, counting, paused}), 32'b11110);
    key2 = 1'b1;
    t0 = s_tick;
    repeat (20) @(negedge clk);
    check_eq("ticks_per_20", 32'(s_tick - t0), 32'd4);

    // Pause on prescaler=2, resume 20 cycles later
    k = 0;
    do begin @(negedge clk); k++; end while (tick != 1'b1 && k < 10);
    key2 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("paused", 32'({state, paused}), 32'b101);
    key2 = 1'b1;
    t0 = s_tick;
    repeat (12) @(negedge clk);
    key2 = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (state != 2'b01 && k < 40);
    check_eq("resume_latency", 32'(k - 1), 32'd7);
    check_eq("pause_no_tick", 32'(s_tick - t0), 32'd0);
    key2 = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (tick != 1'b1 && k < 20);
    check_eq("resume_tick", 32'(k), 32'd2);

    // Long key1 hold: one snapshot, ticks keep coming
    repeat (3) @(negedge clk);
    i0 = s_inc;
    key1 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("freeze", 32'({frozen, disp_load}), 32'b11);
    l0 = s_load;
    repeat (192) @(negedge clk);
    key1 = 1'b1;
    check_eq("inc_200", 32'(s_inc - i0), 32'd40);
    check_eq("frozen_loads", 32'(s_load - l0), 32'd0);

    // Unfreeze: immediate load, then a load on every tick
    repeat (10) @(negedge clk);
    key0 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("unfreeze", 32'({frozen, disp_load}), 32'b01);
    key0 = 1'b1;
    l0 = s_load;
    repeat (50) @(negedge clk);
    check_eq("loads_50", 32'(s_load - l0), 32'd10);

    // key3 and key2 together while frozen: clear wins, key2 is dropped
    key1 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("refreeze", 32'(frozen), 32'd1);
    key1 = 1'b1;
    repeat (10) @(negedge clk);
    c0 = s_clr;
    key3 = 1'b0;
    key2 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("clr_evt", 32'({state, cnt_clr, frozen}), 32'b0010);
    repeat (2) @(negedge clk);
    key3 = 1'b1;
    key2 = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("k2_dropped", 32'(state), 32'd0);
    check_eq("clr_once", 32'(s_clr - c0), 32'd1);
    key2 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("restart", 32'(state), 32'd1);
    key2 = 1'b1;
    repeat (10) @(negedge clk);

    // Bouncing key1 yields a single freeze, only after the steady run
    repeat (3) begin
      key1 = 1'b0;
      repeat (2) @(negedge clk);
      key1 = 1'b1;
      @(negedge clk);
    end
    key1 = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("bounce_quiet", 32'(frozen), 32'd0);
    @(negedge clk);
    key1 = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("bounce_frz", 32'(frozen), 32'd1);

    // key0/key1 in PAUSE are ignored
    repeat (10) @(negedge clk);
    key2 = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("pause2", 32'(paused), 32'd1);
    key2 = 1'b1;
    repeat (10) @(negedge clk);
    l0 = s_load;
    key0 = 1'b0;
    repeat (10) @(negedge clk);
    key0 = 1'b1;
    repeat (10) @(negedge clk);
    key1 = 1'b0;
    repeat (10) @(negedge clk);
    key1 = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("pause_ignore", 32'({frozen, paused}), 32'b11);
    check_eq("pause_loads", 32'(s_load - l0), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Fully synchronous control unit for the stopwatch datapath (centisecond counter, display register, seven-seg/LED drivers).
- Debounces the four raw board keys and turns each press into a single event.
- Generates the 100 Hz count tick from clk.
- Runs the IDLE/RUN/PAUSE state machine and the display-freeze flag; drives clear/increment/load strobes to the datapath. No key edge clocks any register.

Parameters:
- TICK_DIV, 500000: clk cycles per centisecond tick (50 MHz / 100 Hz).
- DEB_CYCLES, 250000: consecutive stable-low clk cycles needed to accept a key press (5 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- key3  in  1  raw key, active-low: reset/clear
- key2  in  1  raw key, active-low: start/pause/resume
- key1  in  1  raw key, active-low: freeze display (lap)
- key0  in  1  raw key, active-low: unfreeze display
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE
- counting  out  1  1 when state != IDLE
- paused  out  1  1 when state == PAUSE
- frozen  out  1  display freeze flag
- tick  out  1  1-cycle pulse every TICK_DIV cycles while RUN
- cnt_clr  out  1  1-cycle strobe: datapath zeroes counter and display
- cnt_inc  out  1  1-cycle strobe: datapath increments counter (wraps at 359999 itself)
- disp_load  out  1  1-cycle strobe: display register <= counter value after this cycle's increment

Behaviour:
- rst (sampled on posedge clk) takes priority over everything and sets:
  - state=IDLE; counting, paused, frozen, tick, cnt_clr, cnt_inc, disp_load = 0.
  - Prescaler and debounce counters = 0; debounced key levels = released.
- Key conditioning, per key:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DEB_CYCLES consecutive identical synchronized samples.
  - A press event evt_kN is a 1-cycle pulse on the debounced released->pressed transition.
  - Holding a key produces no further events. Release produces none.
- Event latency: raw key stable low at cycle 0 -> evt at cycle 2+DEB_CYCLES. The resulting state and strobes are visible the following cycle.
- Simultaneous events in one cycle: priority key3 > key2 > key1 > key0. Only the highest-priority event is acted on; the lower ones are discarded, not queued.
- FSM transitions:
  - any state + evt_k3 -> IDLE. Also: cnt_clr pulse, frozen<=0, prescaler<=0.
  - IDLE + evt_k2 -> RUN. Prescaler starts from 0.
  - RUN + evt_k2 -> PAUSE. Prescaler holds its value.
  - PAUSE + evt_k2 -> RUN. Prescaler resumes from the held value, so no partial tick is lost or gained.
  - RUN + evt_k1 -> frozen<=1 and a disp_load pulse (lap snapshot). Repeated evt_k1 while frozen gives a new snapshot each time.
  - RUN + evt_k0 -> frozen<=0 and a disp_load pulse (immediate catch-up).
  - evt_k1 and evt_k0 in IDLE or PAUSE are ignored. frozen is retained across PAUSE/RUN.
  - evt_k3 in IDLE still pulses cnt_clr.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; tick=1 in the cycle where it equals TICK_DIV-1, then it wraps to 0.
  - cnt_inc = tick (registered together, same cycle).
  - disp_load is also 1 in every tick cycle while frozen=0.
- Same-cycle conflicts:
  - If a key event and tick fall in the same cycle, the tick is honoured first: cnt_inc=1 and the counter increments.
  - The event's effect takes hold the next cycle.
  - A freeze snapshot issued on the tick cycle captures the incremented value.
- Long-pressing any key never stalls tick or cnt_inc.
- All outputs are registered. No combinational path from the key inputs to the outputs.

Test Plan (bench uses TICK_DIV=5, DEB_CYCLES=4):
- rst 3 cycles, then key2 low 10 cycles -> state 00->01 at cycle 7 after key low; first tick 5 cycles later; tick/cnt_inc/disp_load each period; counting=1, paused=0.
- RUN, key2 press at prescaler=2, second press 20 cycles later -> PAUSE with no tick for 20 cycles; next tick 2 cycles after resume lands in RUN.
- RUN, key1 held low 200 cycles -> frozen=1, exactly one extra disp_load at the event; cnt_inc keeps pulsing every 5 cycles, 40 times in total; disp_load only on the event cycle.
- Frozen RUN, key0 press -> frozen=0, one immediate disp_load; disp_load resumes on every tick.
- key3 and key2 debounced to press in the same cycle during RUN -> IDLE, one cnt_clr, frozen=0, key2 discarded; a subsequent key2 press -> RUN.
- key1 bouncing (low 2, high 1, repeated) then held low 6 cycles, in RUN -> exactly one freeze event; key1/key0 presses in PAUSE -> no change to frozen or disp_load.
